// File: rtl/dp_ctrl_pkg.sv
// dp_ctrl_pkg: instruction classes, sequencer states and instruction field positions
package dp_ctrl_pkg;
  typedef enum logic [1:0] {CLS_RR = 2'b00, CLS_RI = 2'b01, CLS_REP = 2'b10, CLS_CMP = 2'b11} cls_e;
  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;
  localparam int CLS_HI = 15;
  localparam int CLS_LO = 14;
  localparam int OP_HI  = 13;
  localparam int OP_LO  = 10;
  localparam int W_HI   = 9;
  localparam int W_LO   = 7;
  localparam int R_HI   = 6;
  localparam int R_LO   = 4;
  localparam int S_HI   = 3;
  localparam int S_LO   = 1;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;
endpackage

// File: rtl/dp_sequencer.sv
// dp_sequencer: two-state instruction sequencer driving the integer datapath controls
module dp_sequencer
  import dp_ctrl_pkg::*;
#(
  parameter int REP_MAX_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  W_Adr,
  output logic [2:0]  R_Adr,
  output logic [2:0]  S_Adr,
  output logic        we,
  output logic [15:0] DS,
  output logic        S_Sel,
  output logic [3:0]  ALU_OP,
  input  logic        N,
  input  logic        Z,
  input  logic        C,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c
);
  state_e state, state_nxt;
  logic [15:0] ir;
  logic [REP_MAX_LOG2-1:0] cnt;
  cls_e cls;
  logic last;
  assign cls = cls_e'(ir[CLS_HI:CLS_LO]);
  assign last = !(cls == CLS_REP && cnt != '0);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      ir     <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= state == EXEC && last;
      if (state == IDLE && instr_valid) begin
        ir  <= instr;
        cnt <= instr[CLS_HI:CLS_LO] == CLS_REP ? REP_MAX_LOG2'(instr[IMM_HI:IMM_LO]) : '0;
      end
      if (state == EXEC) begin
        {flag_n, flag_z, flag_c} <= {N, Z, C};
        if (!last) cnt <= cnt - REP_MAX_LOG2'(1);
      end
    end
  end
  // datapath controls are zero in IDLE and decoded from ir in EXEC
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    busy        = 1'b0;
    W_Adr       = '0;
    R_Adr       = '0;
    S_Adr       = '0;
    DS          = '0;
    S_Sel       = 1'b0;
    ALU_OP      = '0;
    we          = 1'b0;
    if (state == IDLE) begin
      instr_ready = 1'b1;
      state_nxt   = instr_valid ? EXEC : IDLE;
    end else begin
      busy      = 1'b1;
      state_nxt = last ? IDLE : EXEC;
      ALU_OP    = ir[OP_HI:OP_LO];
      W_Adr     = cls == CLS_CMP ? 3'd0 : ir[W_HI:W_LO];
      R_Adr     = cls == CLS_REP ? ir[W_HI:W_LO] : ir[R_HI:R_LO];
      S_Adr     = cls == CLS_REP ? ir[R_HI:R_LO] : cls == CLS_RI ? 3'd0 : ir[S_HI:S_LO];
      DS        = cls == CLS_RI ? {12'h000, ir[IMM_HI:IMM_LO]} : 16'h0000;
      S_Sel     = cls == CLS_RI;
      we        = cls != CLS_CMP;
    end
  end
endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: directed and random instructions checked against an instruction-level model
module tb_dp_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready, busy, done, we, S_Sel;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic [15:0] DS;
  logic [3:0]  ALU_OP;
  logic        N = 1'b0, Z = 1'b0, C = 1'b0;
  logic        flag_n, flag_z, flag_c;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [2:0]  ef = '0;

  always #5 clk = ~clk;

  dp_sequencer #(.REP_MAX_LOG2(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .busy(busy), .done(done),
    .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr), .we(we), .DS(DS),
    .S_Sel(S_Sel), .ALU_OP(ALU_OP), .N(N), .Z(Z), .C(C),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run(input logic [15:0] ins, input bit fixed, input logic [2:0] nzc);
    int cls, ncyc;
    int w, r, s, ds, ss, wen, op;
    bit s_chk, ds_chk;
    logic [2:0] f;
    cls = int'(ins) / 16384;
    op  = (int'(ins) / 1024) % 16;
    w = 0; r = 0; s = 0; ds = 0; ss = 0; wen = 1; ncyc = 1; s_chk = 1; ds_chk = 0;
    case (cls)
      0: begin w = (int'(ins) / 128) % 8; r = (int'(ins) / 16) % 8; s = (int'(ins) / 2) % 8; end
      1: begin w = (int'(ins) / 128) % 8; r = (int'(ins) / 16) % 8; ds = int'(ins) % 16; ss = 1; s_chk = 0; ds_chk = 1; end
      2: begin w = (int'(ins) / 128) % 8; r = w; s = (int'(ins) / 16) % 8; ncyc = int'(ins) % 16 + 1; end
      default: begin r = (int'(ins) / 16) % 8; s = (int'(ins) / 2) % 8; wen = 0; end
    endcase
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    {N, Z, C} = 3'($urandom);
    #1;
    chk("idle_ready", instr_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_we", we, 0);
    chk("idle_waddr", W_Adr, 0);
    chk("idle_done", done, 0);
    chk("idle_flags_hold", {flag_n, flag_z, flag_c}, ef);
    @(posedge clk);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      instr = 16'($urandom);
      f = fixed ? nzc : 3'($urandom);
      {N, Z, C} = f;
      #1;
      chk("exec_busy", busy, 1);
      chk("exec_ready", instr_ready, 0);
      chk("exec_waddr", W_Adr, w);
      chk("exec_raddr", R_Adr, r);
      if (s_chk) chk("exec_saddr", S_Adr, s);
      if (ds_chk) chk("exec_ds", DS, ds);
      chk("exec_ssel", S_Sel, ss);
      chk("exec_aluop", ALU_OP, op);
      chk("exec_we", we, wen);
      chk("exec_done", done, 0);
      if (i == 0) chk("exec_flags_hold", {flag_n, flag_z, flag_c}, ef);
      @(posedge clk);
      ef = f;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_we", we, 0);
    chk("end_flags", {flag_n, flag_z, flag_c}, ef);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", we, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {flag_n, flag_z, flag_c}, 0);
    rst = 1'b1;
    run(16'h0594, 1'b0, 3'b000);
    run(16'h4EDA, 1'b0, 3'b000);
    run(16'h8623, 1'b0, 3'b000);
    run(16'hC0A4, 1'b1, 3'b011);
    chk("cmp_flags", {flag_n, flag_z, flag_c}, 3'b011);
    run(16'h8200, 1'b0, 3'b000);
    run(16'h83AF, 1'b0, 3'b000);
    @(negedge clk);
    instr = 16'h8623;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr = 16'h0000;
    #1;
    chk("midrep_busy1", busy, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrep_we2", we, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b0;
    #1;
    ef = '0;
    chk("midrep_busy", busy, 0);
    chk("midrep_we", we, 0);
    chk("midrep_done", done, 0);
    chk("midrep_ready", instr_ready, 1);
    chk("midrep_flags", {flag_n, flag_z, flag_c}, 0);
    @(negedge clk);
    #1;
    chk("midrep_no_done", done, 0);
    for (int k = 0; k < 40; k++) run(16'($urandom), 1'b0, 3'b000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dp_sequencer.md
DP_SEQUENCER -- requirements
Module: dp_sequencer

Interface
REQ-001 SHALL have parameter REP_MAX_LOG2, default 4, giving the width of the repeat-count field and its counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port instr  input  16  instruction word.
REQ-005 SHALL have port instr_valid  input  1  instr is valid.
REQ-006 SHALL have port instr_ready  output  1  sequencer can accept an instruction.
REQ-007 SHALL have port busy  output  1  instruction in execution.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports W_Adr, R_Adr, S_Adr  output  3 each  datapath register addresses.
REQ-010 SHALL have port we  output  1  register-file write enable.
REQ-011 SHALL have port DS  output  16  datapath immediate operand.
REQ-012 SHALL have port S_Sel  output  1  S-mux select; 1 selects DS.
REQ-013 SHALL have port ALU_OP  output  4  ALU operation code.
REQ-014 SHALL have ports N, Z, C  input  1 each  datapath ALU flags.
REQ-015 SHALL have ports flag_n, flag_z, flag_c  output  1 each  registered status flags.

Function
REQ-016 SHALL decode the instruction class from instr[15:14]: 00 RR, 01 RI, 10 REP, 11 CMP. ALU_OP = instr[13:10] for all classes.
REQ-017 SHALL decode RR as W=[9:7], R=[6:4], S=[3:1], S_Sel=0, we=1; instr[0] is ignored.
REQ-018 SHALL decode RI as W=[9:7], R=[6:4], DS={12'h000, instr[3:0]}, S_Sel=1, we=1.
REQ-019 SHALL decode REP as W=R=[9:7], S=[6:4], count=[3:0], S_Sel=0, we=1, and execute (count+1) consecutive EXEC cycles that accumulate into W.
REQ-020 SHALL decode CMP as R=[6:4], S=[3:1], S_Sel=0, we=0; W_Adr is driven 0.
REQ-021 SHALL have exactly two states, IDLE and EXEC; the state resets to IDLE.
REQ-022 SHALL, in IDLE, drive instr_ready=1 and busy=0, and drive W_Adr, R_Adr, S_Adr, DS, S_Sel, ALU_OP and we all 0.
REQ-023 SHALL, on a rising edge in IDLE with instr_valid=1, latch instr into an instruction register, load the repeat counter from count (REP only), and move to EXEC.
REQ-024 SHALL, in EXEC, drive instr_ready=0 and busy=1, and drive the datapath controls combinationally from the instruction register.
REQ-025 SHALL, at every rising edge in EXEC, load flag_n, flag_z and flag_c from N, Z and C (CMP included).
REQ-026 SHALL, in EXEC for REP with counter != 0, decrement the counter and stay in EXEC; otherwise it SHALL move to IDLE.
REQ-027 SHALL register done: done=1 for exactly the one cycle after the final EXEC cycle, otherwise 0.
REQ-028 SHALL meet this timing: instruction accepted at edge k, writeback at edge k+1, done high in cycle k+1..k+2. The next accept can occur at edge k+2, giving a peak rate of 1 instruction per 2 cycles.
REQ-029 SHALL ignore instr and instr_valid while in EXEC; no instruction is queued.
REQ-030 SHALL run a REP with count=0 as a single EXEC cycle, and a REP with count=2^REP_MAX_LOG2-1 as 16 cycles with no counter wrap.
REQ-031 SHALL leave flag_* unchanged while in IDLE.

Reset
REQ-032 SHALL, when rst=0 at a rising edge, force state IDLE, instruction register 0, counter 0, done 0, and flag_n, flag_z, flag_c 0.
REQ-033 SHALL, on reset during EXEC (including mid-REP), abort the instruction: we=0 from the next cycle and no done pulse.

Structure
REQ-034 SHALL place the class encodings, the state enumeration and the instruction field bit positions in shared package dp_ctrl_pkg.
REQ-035 SHALL be a single flat module with no natural sub-module; the counter and decode are inline. It connects directly to the integer datapath ports of the same names.

Verification
REQ-036 SHALL cover reset: rst=0 for 2 cycles -> instr_ready=1, we=0, done=0, flags 0.
REQ-037 SHALL cover RR: instr=0x0594 accepted -> one EXEC cycle with W_Adr=3, R_Adr=1, S_Adr=2, ALU_OP=1, S_Sel=0, we=1; done high the next cycle.
REQ-038 SHALL cover RI: instr=0x4EDA -> EXEC with W_Adr=5, R_Adr=5, DS=0x000A, S_Sel=1, ALU_OP=3, we=1.
REQ-039 SHALL cover REP: instr=0x8623 -> exactly 4 EXEC cycles with W_Adr=R_Adr=4, S_Adr=2, we=1; instr_ready=0 throughout; a single done pulse.
REQ-040 SHALL cover CMP: instr=0xC0A4 with datapath N=0, Z=1, C=1 -> we=0 and flag_z=1, flag_c=1, flag_n=0 after the edge.
REQ-041 SHALL cover reset mid-REP: rst=0 during the 2nd EXEC cycle of 0x8623 -> IDLE the next cycle with we=0 and no done pulse; instr_valid held 1 during EXEC -> not accepted until IDLE.
